icache_refill_ctrl: RTL and testbench

Miss/refill sequencer for the fetch-stage instruction cache. On a cache miss it stalls the PC register and reads the missing 128-bit line from instruction memory as LINE_WORDS 32-bit beats over a req/ack handshake. It assembles the beats, writes the line into the cache in one cycle, then releases the stall. It sits between the cache (miss, line write port), the PC register (stall) and the instruction memory (beat port).

---
 rtl/icache_refill_ctrl_if.sv | 22 ++
 rtl/icache_refill_ctrl.sv | 161 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Beat-read and cache line-write port bundle for icache_refill_ctrl.
// master = refill controller, slave = instruction memory / cache array side.
interface icache_refill_ctrl_if;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         line_we;
  logic [31:0]  line_addr;
  logic [127:0] line_data;
  logic         fill_done;

  modport master (
    output mem_req, mem_addr, line_we, line_addr, line_data, fill_done,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, line_we, line_addr, line_data, fill_done,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer: stalls fetch, reads a 128-bit line as 4 beats, writes it in one cycle.
// Optional critical-word-first ordering and forwarding: define CRITICAL_WORD_FIRST_EN.
module icache_refill_ctrl #(
  parameter int LINE_WORDS  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 miss,
  input  logic [31:0]          miss_addr,
  output logic                 stall,
  output logic                 busy,
  output logic                 err,
  output logic                 crit_valid,
  output logic [31:0]          crit_data,
  icache_refill_ctrl_if.master bus
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, ERR} state_t;

  state_t         state_r;
  logic [1:0]     beat_r;
  logic [TW-1:0]  tcnt_r;
  logic [27:0]    base_r;
  logic [127:0]   words_r;
  logic           mem_req_r;
  logic [31:0]    mem_addr_r;
  logic           line_we_r;
  logic [31:0]    line_addr_r;
  logic [127:0]   line_data_r;
  logic           busy_r;
  logic           err_r;

  logic           ack_s;
  logic           last_s;
  logic           timeout_s;
  logic [TW-1:0]  tnext_s;
  logic [1:0]     start_s;
  logic [1:0]     last_beat_s;
  logic [127:0]   line_next_s;
  logic           unused_addr_s;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [1:0] w0_r;
  logic       first_r;
  assign start_s     = miss_addr[3:2];
  assign last_beat_s = w0_r - 2'd1;
  assign crit_valid  = first_r & ack_s;
  assign crit_data   = crit_valid ? bus.mem_rdata : 32'h0000_0000;
`else
  assign start_s     = 2'd0;
  assign last_beat_s = 2'(LINE_WORDS - 1);
  assign crit_valid  = 1'b0;
  assign crit_data   = 32'h0000_0000;
`endif

  assign unused_addr_s = ^miss_addr[3:0];

  assign ack_s     = mem_req_r & bus.mem_ack;
  assign last_s    = (beat_r == last_beat_s);
  assign tnext_s   = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
  assign timeout_s = (TIMEOUT_CYC != 0) && (tnext_s == TO_LIM);

  // Stall must react to a miss in the same cycle, so only IDLE passes miss through.
  assign stall         = (state_r == IDLE) ? miss : 1'b1;
  assign busy          = busy_r;
  assign err           = err_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.line_we   = line_we_r;
  assign bus.fill_done = line_we_r;
  assign bus.line_addr = line_addr_r;
  assign bus.line_data = line_data_r;

  // Line image including the beat arriving this cycle.
  always_comb begin
    line_next_s = words_r;
    line_next_s[32*beat_r +: 32] = bus.mem_rdata;
  end

  // Refill sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      beat_r      <= 2'd0;
      tcnt_r      <= '0;
      base_r      <= 28'h0;
      words_r     <= 128'h0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'h0;
      line_we_r   <= 1'b0;
      line_addr_r <= 32'h0;
      line_data_r <= 128'h0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      w0_r        <= 2'd0;
      first_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (miss) begin
            base_r     <= miss_addr[31:4];
            beat_r     <= start_s;
            tcnt_r     <= '0;
            mem_req_r  <= 1'b1;
            mem_addr_r <= {miss_addr[31:4], start_s, 2'b00};
            busy_r     <= 1'b1;
            state_r    <= REQ;
`ifdef CRITICAL_WORD_FIRST_EN
            w0_r       <= start_s;
            first_r    <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (ack_s) begin
            words_r[32*beat_r +: 32] <= bus.mem_rdata;
            tcnt_r <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            first_r <= 1'b0;
`endif
            if (last_s) begin
              mem_req_r   <= 1'b0;
              line_we_r   <= 1'b1;
              line_addr_r <= {base_r, 4'h0};
              line_data_r <= line_next_s;
              state_r     <= WRITE;
            end else begin
              beat_r     <= beat_r + 2'd1;
              mem_addr_r <= {base_r, beat_r + 2'd1, 2'b00};
            end
          end else if (timeout_s) begin
            tcnt_r    <= tnext_s;
            mem_req_r <= 1'b0;
            err_r     <= 1'b1;
            state_r   <= ERR;
          end else begin
            tcnt_r <= tnext_s;
          end
        end
        WRITE: begin
          line_we_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
        ERR: begin
          state_r <= ERR;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl against a queue-based refill model.
module tb_icache_refill_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] miss_addr = 32'h0;
  logic        stall, busy, err, crit_valid;
  logic [31:0] crit_data;

  icache_refill_ctrl_if bus();

  icache_refill_ctrl #(.LINE_WORDS(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .miss(miss), .miss_addr(miss_addr),
    .stall(stall), .busy(busy), .err(err),
    .crit_valid(crit_valid), .crit_data(crit_data), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           pend[$];          // word indices still to be fetched, in order
  bit           m_wr = 1'b0;
  bit           m_err = 1'b0;
  logic [31:0]  m_base = 32'h0;
  logic [127:0] m_words = 128'h0;
  logic [127:0] m_ldata = 128'h0;
  logic [31:0]  m_laddr = 32'h0;
  int           m_wait = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend.delete();
      m_wr = 1'b0; m_err = 1'b0; m_base = 32'h0; m_words = 128'h0;
      m_ldata = 128'h0; m_laddr = 32'h0; m_wait = 0;
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_wr) begin
      m_wr = 1'b0;
    end else if (pend.size() > 0) begin
      if (bus.mem_ack) begin
        m_words[32*pend[0] +: 32] = bus.mem_rdata;
        void'(pend.pop_front());
        m_wait = 0;
        if (pend.size() == 0) begin
          m_wr = 1'b1;
          m_laddr = m_base;
          m_ldata = m_words;
        end
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_err = 1'b1;
          pend.delete();
        end
      end
    end else if (miss) begin
      int w0;
`ifdef CRITICAL_WORD_FIRST_EN
      w0 = int'(miss_addr[3:2]);
`else
      w0 = 0;
`endif
      m_base = {miss_addr[31:4], 4'h0};
      for (int k = 0; k < 4; k++) pend.push_back((w0 + k) % 4);
      m_wait = 0;
    end
  end

  // ---------------- compare process + recorders ----------------
  logic [31:0]  acc_q[$];
  int           n_fill = 0;
  int           n_reqcyc = 0;
  logic [127:0] last_line = 128'h0;

  initial forever begin
    bit e_req;
    @(negedge clk);
    e_req = (pend.size() > 0);
    chk("stall", stall, m_err || m_wr || e_req || miss);
    chk("busy", busy, m_err || m_wr || e_req);
    chk("mem_req", bus.mem_req, e_req);
    chk("err", err, m_err);
    chk("line_we", bus.line_we, m_wr);
    chk("fill_done", bus.fill_done, m_wr);
    chk("line_addr", bus.line_addr, m_laddr);
    chk("line_data", bus.line_data, m_ldata);
    if (e_req) chk("mem_addr", bus.mem_addr, m_base + 32'(4 * pend[0]));
`ifdef CRITICAL_WORD_FIRST_EN
    chk("crit_valid", crit_valid, e_req && pend.size() == 4 && bus.mem_ack);
    if (crit_valid) chk("crit_data", crit_data, bus.mem_rdata);
`else
    chk("crit_valid", crit_valid, 1'b0);
    chk("crit_data", crit_data, 32'h0);
`endif
    if (bus.mem_req && bus.mem_ack) acc_q.push_back(bus.mem_addr);
    if (bus.mem_req) n_reqcyc++;
    if (bus.line_we) begin
      n_fill++;
      last_line = bus.line_data;
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_data = 1'b0;

  task automatic step(input bit m, input logic [31:0] a, input bit ack);
    miss = m;
    miss_addr = a;
    bus.mem_ack = ack;
    bus.mem_rdata = rnd_data ? $urandom : (32'hA0 + {30'd0, bus.mem_addr[3:2]});
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input int max_cyc, input int ack_every, output int fill_cyc);
    fill_cyc = 0;
    for (int c = 1; c <= max_cyc && n_fill == 0; c++) begin
      step(1'b0, $urandom, (c % ack_every) == 0);
      if (n_fill != 0) fill_cyc = c;
    end
  endtask

  logic [31:0]  exp_a[4];
  logic [127:0] exp_line;
  int           fc;
  int           gap;

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
`ifdef CRITICAL_WORD_FIRST_EN
    exp_a = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
`else
    exp_a = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
`endif
    exp_line = 128'h000000A3_000000A2_000000A1_000000A0;

    // reset state
    #1;
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("rst_stall_follows_miss", stall, 1'b1);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_line_data", bus.line_data, 128'h0);
    chk("rst_busy_err", {busy, err, bus.line_we}, 3'b000);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    chk("idle_stall", stall, 1'b0);
    chk("idle_mem_req", bus.mem_req, 1'b0);

    // basic refill, ack every cycle
    acc_q.delete(); n_fill = 0;
    step(1'b1, 32'h0000_1234, 1'b1);
    run_fill(20, 1, fc);
    chk("basic_fill_count", n_fill, 1);
    chk("basic_penalty", fc, 5);
    chk("basic_stall_release", stall, 1'b0);
    chk("basic_beats", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk($sformatf("basic_addr%0d", i), acc_q[i], exp_a[i]);
    chk("basic_line", last_line, exp_line);

    // ack backpressure: ack on every 3rd cycle
    acc_q.delete(); n_fill = 0;
    step(1'b1, 32'h0000_1234, 1'b0);
    run_fill(60, 3, fc);
    chk("bp_fill_count", n_fill, 1);
    chk("bp_beats", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk($sformatf("bp_addr%0d", i), acc_q[i], exp_a[i]);
    chk("bp_line", last_line, exp_line);

    // timeout: no ack ever
    n_fill = 0; n_reqcyc = 0;
    step(1'b1, 32'h0000_4440, 1'b0);
    for (int c = 0; c < 30 && !err; c++) step(1'b0, 32'h0, 1'b0);
    chk("to_req_cycles", n_reqcyc, TO);
    chk("to_err", err, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("to_hold_stall_err", {stall, err, bus.mem_req}, 3'b110);
    chk("to_no_fill", n_fill, 0);
    rst_n = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    chk("to_err_cleared", err, 1'b0);

    // reset after two beats, then clean refill of 0x2000
    n_fill = 0;
    step(1'b1, 32'h0000_2000, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    chk("midrst_no_fill", n_fill, 0);
    acc_q.delete();
    step(1'b1, 32'h0000_2000, 1'b1);
    run_fill(20, 1, fc);
    chk("midrst_refill", n_fill, 1);
    chk("midrst_beats", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk($sformatf("midrst_addr%0d", i), acc_q[i], 32'h2000 + 32'(4 * i));
    chk("midrst_line", last_line, exp_line);

    // randomized traffic
    rnd_data = 1'b1;
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      bit ack;
      ack = ($urandom_range(0, 99) < 60) || (gap >= 5);
      gap = ack ? 0 : gap + 1;
      if (err || $urandom_range(0, 249) == 0) rst_n = 1'b0;
      step($urandom_range(0, 3) == 0, $urandom, ack);
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
